// File: rtl/seq_mult_256bit.sv
// -----------------------------------------------------------------------------
// seq_mult_256bit
//
// Purpose:
//   Sequential unsigned 256 x 256 -> 512-bit shift-add multiplier. It is the
//   shared multiply engine of the ed25519 point arithmetic. It performs no
//   modular reduction; the caller truncates or reduces the product.
//
// Operation:
//   A start request in IDLE latches the operands. The multiplicand goes into a
//   512-bit shift register, zero-extended. The multiplier goes into a 256-bit
//   register. Every RUN cycle then retires one multiplier digit into a private
//   accumulator. When the last digit has been retired, the final sum is copied
//   into the product register and done2 pulses for one cycle.
//
// Configuration macro:
//   SEQ_MULT_RADIX4_EN
//     undefined (default): radix-2, 1 multiplier bit per step, 256 steps.
//     defined:             radix-4, 2 multiplier bits per step, 128 steps
//                          (partial products 0, a, 2a, 3a).
//
// Ports:
//   clk      in   1    rising-edge clock
//   rst      in   1    synchronous reset, active-high; dominates start and
//                      aborts any operation in progress
//   start    in   1    one-cycle request; a/b sampled on the same edge;
//                      ignored while an operation is running
//   a        in   256  multiplicand, unsigned
//   b        in   256  multiplier, unsigned
//   product  out  512  registered a*b; held until the next completion
//   done2    out  1    one-cycle pulse: product valid this cycle
// -----------------------------------------------------------------------------
module seq_mult_256bit (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [255:0] a,
    input  logic [255:0] b,
    output logic [511:0] product,
    output logic         done2
);

`ifdef SEQ_MULT_RADIX4_EN
    localparam int unsigned STEP_BITS = 2;
    localparam logic [7:0]  LAST_STEP = 8'd127;
`else
    localparam int unsigned STEP_BITS = 1;
    localparam logic [7:0]  LAST_STEP = 8'd255;
`endif

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Partial product for one multiplier digit. The shifted multiplicand
    // holds at most 256 + 254 significant bits. So 3*a_sh still fits in
    // 512 bits, and no carry is lost.
    function automatic logic [511:0] partial_product(
        input logic [511:0]          a_sh_v,
        input logic [STEP_BITS-1:0]  digit_v
    );
        logic [511:0] pp_v;
`ifdef SEQ_MULT_RADIX4_EN
        case (digit_v)
            2'b00:   pp_v = 512'd0;
            2'b01:   pp_v = a_sh_v;
            2'b10:   pp_v = a_sh_v << 1;
            2'b11:   pp_v = a_sh_v + (a_sh_v << 1);
            default: pp_v = 512'd0;
        endcase
`else
        if (digit_v[0]) begin
            pp_v = a_sh_v;
        end else begin
            pp_v = 512'd0;
        end
`endif
        return pp_v;
    endfunction

    state_t         state_q,   state_d;
    logic [511:0]   a_sh_q,    a_sh_d;
    logic [255:0]   b_q,       b_d;
    logic [511:0]   acc_q,     acc_d;
    logic [7:0]     cnt_q,     cnt_d;
    logic [511:0]   product_q, product_d;
    logic           done_q,    done_d;
    logic [511:0]   acc_sum_s;

    // Next-state logic: operand capture, one multiply step per RUN cycle,
    // and completion handling.
    always_comb begin
        state_d   = state_q;
        a_sh_d    = a_sh_q;
        b_d       = b_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        done_d    = 1'b0;
        acc_sum_s = acc_q + partial_product(a_sh_q, b_q[STEP_BITS-1:0]);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_sh_d  = {256'd0, a};
                    b_d     = b;
                    acc_d   = 512'd0;
                    cnt_d   = 8'd0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                // start is deliberately not looked at here; the operands stay
                // frozen for the whole run.
                acc_d  = acc_sum_s;
                a_sh_d = a_sh_q << STEP_BITS;
                b_d    = b_q >> STEP_BITS;
                if (cnt_q == LAST_STEP) begin
                    // The final digit is folded in on this same edge, so the
                    // product comes from the sum and not from acc_q.
                    product_d = acc_sum_s;
                    done_d    = 1'b1;
                    cnt_d     = 8'd0;
                    state_d   = ST_IDLE;
                end else begin
                    cnt_d     = cnt_q + 8'd1;
                    state_d   = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            a_sh_q    <= 512'd0;
            b_q       <= 256'd0;
            acc_q     <= 512'd0;
            cnt_q     <= 8'd0;
            product_q <= 512'd0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_sh_q    <= a_sh_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            done_q    <= done_d;
        end
    end

    assign product = product_q;
    assign done2   = done_q;

endmodule

// File: tb/tb_seq_mult_256bit.sv
// -----------------------------------------------------------------------------
// tb_seq_mult_256bit
//
// Self-checking bench for seq_mult_256bit. It applies a table of operand and
// expected-product records. A scoreboard queue receives each expected product
// when the operation is issued, and the done2 monitor pops and compares it.
// Hand-written sequences cover reset, start ignored during RUN, back-to-back
// start in the done2 cycle, and reset abort. Define SEQ_MULT_RADIX4_EN on both
// the bench and the RTL for the radix-4 build.
// -----------------------------------------------------------------------------
module tb_seq_mult_256bit;

`ifdef SEQ_MULT_RADIX4_EN
    localparam int LAT = 128;
`else
    localparam int LAT = 256;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [255:0] a;
    logic [255:0] b;
    logic [511:0] product;
    logic         done2;

    int           checks    = 0;
    int           errors    = 0;
    int           cyc       = 0;
    int           start_cyc = 0;
    logic [511:0] exp_q[$];
    logic [511:0] mon_exp;

    typedef struct {
        string        nm;
        logic [255:0] a;
        logic [255:0] b;
        logic [511:0] e;
    } vec_t;

    vec_t vecs[9];

    seq_mult_256bit dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .product (product),
        .done2   (done2)
    );

    always #5 clk = ~clk;

    // Posedge counter used for the latency measurement.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Scoreboard: every done2 pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (done2 === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done2: got done2=1 product=%0h expected no pulse", product);
            end else begin
                mon_exp = exp_q.pop_front();
                check("scoreboard_product", product, mon_exp);
            end
        end
    end

    // Called at a negedge; drives one start pulse and leaves the bench at
    // the negedge after the start edge.
    task automatic issue(input logic [255:0] ta, input logic [255:0] tb2, input logic [511:0] e);
        a     = ta;
        b     = tb2;
        start = 1'b1;
        exp_q.push_back(e);
        @(negedge clk);
        start     = 1'b0;
        start_cyc = cyc;
    endtask

    // Waits (bounded) for done2 and checks the pulse arrives exactly LAT edges
    // after the start edge. Returns at the negedge where done2 is seen.
    task automatic wait_done(input string nm);
        int n;
        n = 0;
        while (done2 !== 1'b1 && n < LAT + 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (done2 !== 1'b1) begin
            errors++;
            $display("FAIL %s_timeout: got no done2 within %0d cycles expected done2 at %0d", nm, LAT + 40, LAT);
        end else if (cyc - start_cyc != LAT) begin
            errors++;
            $display("FAIL %s_latency: got %0d expected %0d", nm, cyc - start_cyc, LAT);
        end
    endtask

    task automatic pulse_end(input string nm);
        @(negedge clk);
        check(nm, {511'd0, done2}, 512'd0);
    endtask

    task automatic count_done(input int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            @(negedge clk);
            if (done2 === 1'b1) cnt++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion expected $finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [255:0] ones;
        int           cnt;
        logic         hold_ok;

        ones = {256{1'b1}};
        vecs[0] = '{"small_3x5",    256'd3,           256'd5,           512'd15};
        vecs[1] = '{"max_x_max",    ones,             ones,             {512{1'b1}} - (512'd1 << 257) + 512'd2};
        vecs[2] = '{"zero_a",       256'd0,           256'd123,         512'd0};
        vecs[3] = '{"zero_b",       256'd123,         256'd0,           512'd0};
        vecs[4] = '{"one_x_max",    256'd1,           ones,             {256'd0, ones}};
        vecs[5] = '{"msb_x_two",    256'd1 << 255,    256'd2,           512'd1 << 256};
        vecs[6] = '{"max_x_two",    ones,             256'd2,           {255'd0, ones, 1'b0}};
        vecs[7] = '{"word_shift",   256'hDEADBEEF,    256'h1_0000_0000, 512'hDEADBEEF_0000_0000};
        vecs[8] = '{"ffff_sq",      256'hFFFF,        256'hFFFF,        512'hFFFE_0001};

        // Reset with start held high: nothing starts, outputs stay zero.
        rst   = 1'b1;
        start = 1'b1;
        a     = 256'd3;
        b     = 256'd5;
        @(negedge clk);
        check("reset_product_c1", product, 512'd0);
        check("reset_done2_c1", {511'd0, done2}, 512'd0);
        @(negedge clk);
        check("reset_product_c2", product, 512'd0);
        check("reset_done2_c2", {511'd0, done2}, 512'd0);
        rst   = 1'b0;
        start = 1'b0;
        count_done(LAT + 40, cnt);
        check("reset_no_op", cnt, 512'd0);

        // Table-driven vectors.
        for (int i = 0; i < 9; i++) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].e);
            wait_done(vecs[i].nm);
            pulse_end({vecs[i].nm, "_pulse_width"});
        end

        // Operand change and second start during RUN are ignored.
        issue(256'h1234, 256'h10, 512'h12340);
        repeat (20) @(negedge clk);
        a     = 256'hFFFF;
        b     = 256'hFFFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a     = 256'h55;
        wait_done("midrun_ignore");
        pulse_end("midrun_pulse_width");
        count_done(LAT + 40, cnt);
        check("midrun_no_second_op", cnt, 512'd0);

        // Start in the done2 cycle: back-to-back operation, product held.
        issue(256'd11, 256'd13, 512'd143);
        wait_done("b2b_first");
        issue(256'd25, 256'd4, 512'd100);
        hold_ok = 1'b1;
        repeat (LAT - 5) begin
            if (product !== 512'd143) hold_ok = 1'b0;
            @(negedge clk);
        end
        check("b2b_product_hold", {511'd0, hold_ok}, 512'd1);
        wait_done("b2b_second");
        pulse_end("b2b_pulse_width");

        // Reset mid-RUN aborts the operation and clears the product.
        issue(256'd100, 256'd200, 512'd20000);
        repeat (50) @(negedge clk);
        rst = 1'b1;
        void'(exp_q.pop_back());
        @(negedge clk);
        check("abort_product", product, 512'd0);
        check("abort_done2", {511'd0, done2}, 512'd0);
        rst = 1'b0;
        count_done(LAT + 40, cnt);
        check("abort_no_done", cnt, 512'd0);
        issue(256'd7, 256'd9, 512'd63);
        wait_done("after_abort");
        pulse_end("after_abort_pulse_width");

        check("scoreboard_empty", exp_q.size(), 512'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
